// File: rtl/lc3_pkg.sv
// rtl/lc3_pkg.sv - shared LC-3 opcodes, branch-unit FSM states and helpers
package lc3_pkg;

   localparam int LC3_DATA_W = 16;

   localparam logic [3:0] OP_BR  = 4'b0000;
   localparam logic [3:0] OP_JMP = 4'b1100;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_EVAL = 3'd1,
      ST_LOAD = 3'd2,
      ST_DONE = 3'd3,
      ST_ERR  = 3'd4
   } br_state_t;

   // BR condition: any requested flag that is currently set enables the branch
   function automatic logic br_enable(input logic [2:0] cond,
                                      input logic       n,
                                      input logic       z,
                                      input logic       p);
      return (cond[2] & n) | (cond[1] & z) | (cond[0] & p);
   endfunction

endpackage

// File: rtl/lc3_sext.sv
// rtl/lc3_sext.sv - parameterised sign extender
module lc3_sext #(
   parameter int IN_W  = 9,
   parameter int OUT_W = 16
) (
   input  logic [IN_W-1:0]  i_In,
   output logic [OUT_W-1:0] o_Out
);

   assign o_Out = {{(OUT_W-IN_W){i_In[IN_W-1]}}, i_In};

endmodule

// File: rtl/lc3_branch_unit.sv
// rtl/lc3_branch_unit.sv - BR/JMP resolution and PC load handshake
module lc3_branch_unit
   import lc3_pkg::*;
#(
   parameter int DATA_W      = LC3_DATA_W,
   parameter int OFFSET_W    = 9,
   parameter int ACK_TIMEOUT = 15
) (
   input  logic              i_Clk,
   input  logic              i_Rst_n,
   input  logic              i_Start,
   input  logic [DATA_W-1:0] i_IR,
   input  logic [DATA_W-1:0] i_PC,
   input  logic [DATA_W-1:0] i_BaseR_Data,
   input  logic              i_N,
   input  logic              i_Z,
   input  logic              i_P,
   input  logic              i_PC_Ack,
   output logic              o_Busy,
   output logic              o_BEN,
   output logic              o_LD_PC,
   output logic [DATA_W-1:0] o_PC_Next,
   output logic              o_Done,
   output logic              o_Err
);

   // +2 keeps the width at least 1 bit even when the timeout is disabled
   localparam int CNT_W = $clog2(ACK_TIMEOUT + 2);

   br_state_t         state_q, state_d;
   logic [DATA_W-1:0] ir_q, pc_q, base_q;
   logic [2:0]        nzp_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              ben_q;
   logic [DATA_W-1:0] pc_next_q;

   logic [DATA_W-1:0] offset_sext;
   logic [3:0]        opcode;
   logic              eval_legal;
   logic              eval_ben;
   logic [DATA_W-1:0] eval_target;
   logic              timeout_hit;

   lc3_sext #(
      .IN_W  (OFFSET_W),
      .OUT_W (DATA_W)
   ) u_sext (
      .i_In  (ir_q[OFFSET_W-1:0]),
      .o_Out (offset_sext)
   );

   assign opcode = ir_q[DATA_W-1 -: 4];

   // The limit is reached on the edge where the count would step to ACK_TIMEOUT
   assign timeout_hit = (ACK_TIMEOUT != 0) && (cnt_q == CNT_W'(ACK_TIMEOUT - 1));

   // Decode the captured instruction into legality, branch enable and target
   always_comb begin
      eval_legal  = 1'b0;
      eval_ben    = 1'b0;
      eval_target = '0;
      case (opcode)
         OP_BR: begin
            eval_legal  = 1'b1;
            eval_ben    = br_enable(ir_q[11:9], nzp_q[2], nzp_q[1], nzp_q[0]);
            eval_target = pc_q + offset_sext;
         end
         OP_JMP: begin
            eval_legal  = 1'b1;
            eval_ben    = 1'b1;
            eval_target = base_q;
         end
         default: ;
      endcase
   end

   // FSM state register
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   // FSM next-state logic; ack takes priority over the timeout on the same edge
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (i_Start) state_d = ST_EVAL;
         ST_EVAL: begin
            if (!eval_legal)   state_d = ST_ERR;
            else if (eval_ben) state_d = ST_LOAD;
            else               state_d = ST_DONE;
         end
         ST_LOAD: begin
            if (i_PC_Ack)         state_d = ST_DONE;
            else if (timeout_hit) state_d = ST_ERR;
         end
         ST_DONE: state_d = ST_IDLE;
         ST_ERR:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Capture operands only when a request is accepted in IDLE
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         ir_q   <= '0;
         pc_q   <= '0;
         base_q <= '0;
         nzp_q  <= 3'b000;
      end else if (state_q == ST_IDLE && i_Start) begin
         ir_q   <= i_IR;
         pc_q   <= i_PC;
         base_q <= i_BaseR_Data;
         nzp_q  <= {i_N, i_Z, i_P};
      end
   end

   // Register BEN and target in EVAL; target clears on the way back to IDLE
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         ben_q     <= 1'b0;
         pc_next_q <= '0;
      end else if (state_q == ST_EVAL) begin
         ben_q     <= eval_ben;
         pc_next_q <= eval_target;
      end else if (state_q == ST_DONE || state_q == ST_ERR) begin
         pc_next_q <= '0;
      end
   end

   // Count un-acked LOAD cycles; zero everywhere else so each LOAD starts fresh
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n)
         cnt_q <= '0;
      else if (state_q == ST_LOAD && !i_PC_Ack && ACK_TIMEOUT != 0)
         cnt_q <= cnt_q + 1'b1;
      else
         cnt_q <= '0;
   end

   assign o_Busy    = (state_q != ST_IDLE);
   assign o_LD_PC   = (state_q == ST_LOAD);
   assign o_Done    = (state_q == ST_DONE);
   assign o_Err     = (state_q == ST_ERR);
   assign o_BEN     = ben_q;
   assign o_PC_Next = pc_next_q;

endmodule

// File: tb/tb_lc3_branch_unit.sv
// tb/tb_lc3_branch_unit.sv - directed table-driven bench for lc3_branch_unit
module tb_lc3_branch_unit;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [15:0] ir, pc, baser;
   logic        n, z, p;
   logic        ack;
   logic        busy, ben, ld_pc, done, err;
   logic [15:0] pc_next;

   int passed = 0;
   int total  = 0;

   typedef struct {
      logic [15:0] ir;
      logic [15:0] pc;
      logic [15:0] baser;
      logic [2:0]  nzp;
      int          ack_dly;
      logic        exp_err;
      logic        exp_ben;
      logic [15:0] exp_pc;
   } vec_t;

   vec_t vecs[10];

   lc3_branch_unit #(
      .DATA_W      (16),
      .OFFSET_W    (9),
      .ACK_TIMEOUT (15)
   ) dut (
      .i_Clk        (clk),
      .i_Rst_n      (rst_n),
      .i_Start      (start),
      .i_IR         (ir),
      .i_PC         (pc),
      .i_BaseR_Data (baser),
      .i_N          (n),
      .i_Z          (z),
      .i_P          (p),
      .i_PC_Ack     (ack),
      .o_Busy       (busy),
      .o_BEN        (ben),
      .o_LD_PC      (ld_pc),
      .o_PC_Next    (pc_next),
      .o_Done       (done),
      .o_Err        (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic issue(input logic [15:0] t_ir, input logic [15:0] t_pc,
                        input logic [15:0] t_base, input logic [2:0] t_nzp);
      @(negedge clk);
      ir = t_ir; pc = t_pc; baser = t_base; {n, z, p} = t_nzp;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      string tag;
      tag = $sformatf("v%0d", idx);
      issue(v.ir, v.pc, v.baser, v.nzp);
      chk({tag, "_eval_busy"}, busy, 1);
      chk({tag, "_eval_quiet"}, {ld_pc, done, err}, 3'b000);
      @(negedge clk);
      if (v.exp_err) begin
         chk({tag, "_err"}, {err, done, ld_pc}, 3'b100);
      end else if (!v.exp_ben) begin
         chk({tag, "_nt_done"}, {done, err, ld_pc}, 3'b100);
         chk({tag, "_nt_ben"}, ben, 0);
      end else begin
         for (int k = 0; k <= v.ack_dly; k++) begin
            if (k > 0) @(negedge clk);
            chk({tag, "_ld_pc"}, {ld_pc, done, err}, 3'b100);
            chk({tag, "_pc_next"}, pc_next, v.exp_pc);
            if (k == v.ack_dly) ack = 1'b1;
         end
         @(negedge clk);
         ack = 1'b0;
         chk({tag, "_t_done"}, {done, err, ld_pc}, 3'b100);
         chk({tag, "_t_ben"}, ben, 1);
      end
      @(negedge clk);
      chk({tag, "_idle"}, {busy, done, err, ld_pc}, 4'b0000);
      chk({tag, "_idle_pc"}, pc_next, 16'h0000);
      chk({tag, "_ben_hold"}, ben, v.exp_ben);
   endtask

   initial begin
      int cnt;
      rst_n = 1'b0; start = 1'b0; ack = 1'b0;
      ir = '0; pc = '0; baser = '0; {n, z, p} = 3'b000;

      vecs[0] = '{16'h0405, 16'h3001, 16'h0000, 3'b010, 0,  1'b0, 1'b1, 16'h3006};
      vecs[1] = '{16'h0805, 16'h3001, 16'h0000, 3'b001, 0,  1'b0, 1'b0, 16'h0000};
      vecs[2] = '{16'h0FFF, 16'h0000, 16'h0000, 3'b100, 0,  1'b0, 1'b1, 16'hFFFF};
      vecs[3] = '{16'h0FFF, 16'h0000, 16'h0000, 3'b000, 0,  1'b0, 1'b0, 16'h0000};
      vecs[4] = '{16'hC1C0, 16'h3000, 16'h1234, 3'b001, 3,  1'b0, 1'b1, 16'h1234};
      vecs[5] = '{16'h1021, 16'h3000, 16'h0000, 3'b010, 0,  1'b1, 1'b0, 16'h0000};
      vecs[6] = '{16'h0010, 16'h3000, 16'h0000, 3'b111, 0,  1'b0, 1'b0, 16'h0000};
      vecs[7] = '{16'hC080, 16'h3000, 16'hABCD, 3'b100, 1,  1'b0, 1'b1, 16'hABCD};
      vecs[8] = '{16'h03F0, 16'h3010, 16'h0000, 3'b001, 0,  1'b0, 1'b1, 16'h3000};
      vecs[9] = '{16'hC1C0, 16'h3000, 16'h5555, 3'b010, 14, 1'b0, 1'b1, 16'h5555};

      repeat (2) @(negedge clk);
      chk("reset_outs", {busy, ben, ld_pc, done, err}, 5'b00000);
      chk("reset_pc", pc_next, 16'h0000);
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

      // ack never arrives: LOAD lasts exactly 15 cycles, then ERR
      issue(16'hC1C0, 16'h3000, 16'h4444, 3'b000);
      @(negedge clk);
      cnt = 0;
      while (ld_pc === 1'b1 && cnt < 40) begin
         cnt++;
         if (done !== 1'b0) chk("to_no_done", done, 0);
         @(negedge clk);
      end
      chk("to_len", cnt, 15);
      chk("to_err", {err, done, ld_pc}, 3'b100);
      @(negedge clk);
      chk("to_idle", {busy, err}, 2'b00);

      // start re-pulsed while busy is dropped, not queued
      issue(16'h0805, 16'h3001, 16'h0000, 3'b001);
      start = 1'b1;
      ir = 16'hC1C0;
      @(negedge clk);
      chk("rp_done", done, 1);
      start = 1'b0;
      @(negedge clk);
      chk("rp_idle", busy, 0);
      @(negedge clk);
      chk("rp_stay_idle", busy, 0);

      // asynchronous reset in LOAD clears outputs without waiting for a clock
      issue(16'hC1C0, 16'h3000, 16'h7777, 3'b000);
      @(negedge clk);
      chk("rl_in_load", ld_pc, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("rl_outs", {busy, ben, ld_pc, done, err}, 5'b00000);
      chk("rl_pc", pc_next, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rl_idle", {busy, ld_pc}, 2'b00);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
